// File: rtl/rob_gen.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order retire,
// with precise-exception squash and external flush.
module rob_gen #(
  parameter int  DEPTH      = 16,
  parameter int  DISPATCH_W = 2,
  parameter int  RETIRE_W   = 2,
  parameter int  WB_PORTS   = 4,
  parameter int  DATA_W     = 32,
  localparam int TAG_W      = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [DISPATCH_W-1:0]        disp_valid,
  input  logic [DISPATCH_W*5-1:0]      disp_dst,
  input  logic [DISPATCH_W*32-1:0]     disp_pc,
  output logic                         disp_ready,
  output logic [DISPATCH_W*TAG_W-1:0]  disp_tag,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
  input  logic [WB_PORTS-1:0]          wb_exc,
  output logic [RETIRE_W-1:0]          ret_valid,
  output logic [RETIRE_W*5-1:0]        ret_dst,
  output logic [RETIRE_W*DATA_W-1:0]   ret_data,
  output logic                         exc_valid,
  output logic [31:0]                  exc_pc,
  input  logic                         flush,
  output logic [TAG_W:0]               count
);
  localparam int PTR_W = TAG_W + 1;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]  vld_q, vld_d, cmp_q, cmp_d, exc_q, exc_d;
  logic [4:0]        dst_q  [DEPTH];
  logic [4:0]        dst_d  [DEPTH];
  logic [31:0]       pc_q   [DEPTH];
  logic [31:0]       pc_d   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic [PTR_W:0]    free_slots;
  logic [PTR_W-1:0]  n_alloc, n_ret;
  logic [TAG_W-1:0]  lane_tag [DISPATCH_W];
  logic              squash, disp_fire;

  // Pointer difference modulo 2*DEPTH gives 0..DEPTH, so full and empty stay distinct.
  assign count      = tail_q - head_q;
  assign free_slots = (PTR_W+1)'(DEPTH) - {1'b0, count};
  assign disp_ready = free_slots >= (PTR_W+1)'(DISPATCH_W);
  assign squash     = flush | exc_valid;
  assign disp_fire  = disp_ready & ~squash;

  always_comb begin
    logic [TAG_W-1:0] t;
    t        = tail_q[TAG_W-1:0];
    n_alloc  = '0;
    disp_tag = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      lane_tag[i] = t;
      if (resetn) disp_tag[i*TAG_W +: TAG_W] = t;
      if (disp_valid[i]) begin
        t       = t + 1'b1;
        n_alloc = n_alloc + 1'b1;
      end
    end
  end

  // Retire window walks from head and stops at the first entry not ready to leave.
  always_comb begin
    logic             stop;
    logic [TAG_W-1:0] idx;
    stop      = flush;
    n_ret     = '0;
    ret_valid = '0;
    ret_dst   = '0;
    ret_data  = '0;
    exc_valid = 1'b0;
    exc_pc    = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      idx = head_q[TAG_W-1:0] + TAG_W'(i);
      if (!stop) begin
        if (vld_q[idx] && cmp_q[idx] && !exc_q[idx]) begin
          ret_valid[i]                 = 1'b1;
          ret_dst[i*5 +: 5]            = dst_q[idx];
          ret_data[i*DATA_W +: DATA_W] = data_q[idx];
          n_ret                        = n_ret + 1'b1;
        end else begin
          if (vld_q[idx] && cmp_q[idx]) begin
            exc_valid = 1'b1;
            exc_pc    = pc_q[idx];
          end
          stop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic [TAG_W-1:0] idx;
    head_d = head_q + n_ret;
    tail_d = tail_q;
    vld_d  = vld_q;
    cmp_d  = cmp_q;
    exc_d  = exc_q;
    dst_d  = dst_q;
    pc_d   = pc_q;
    data_d = data_q;

    for (int i = 0; i < RETIRE_W; i++) begin
      idx = head_q[TAG_W-1:0] + TAG_W'(i);
      if (ret_valid[i]) vld_d[idx] = 1'b0;
    end

    // Ascending port order lets the highest port win on a tag collision.
    for (int p = 0; p < WB_PORTS; p++) begin
      idx = wb_tag[p*TAG_W +: TAG_W];
      if (wb_valid[p] && vld_q[idx]) begin
        cmp_d[idx]  = 1'b1;
        exc_d[idx]  = wb_exc[p];
        data_d[idx] = wb_data[p*DATA_W +: DATA_W];
      end
    end

    if (disp_fire) begin
      for (int i = 0; i < DISPATCH_W; i++) begin
        if (disp_valid[i]) begin
          vld_d[lane_tag[i]] = 1'b1;
          cmp_d[lane_tag[i]] = 1'b0;
          exc_d[lane_tag[i]] = 1'b0;
          dst_d[lane_tag[i]] = disp_dst[i*5 +: 5];
          pc_d[lane_tag[i]]  = disp_pc[i*32 +: 32];
        end
      end
      tail_d = tail_q + n_alloc;
    end

    if (squash) begin
      vld_d  = '0;
      cmp_d  = '0;
      exc_d  = '0;
      head_d = tail_q;
      tail_d = tail_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
      cmp_q  <= '0;
      exc_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
      cmp_q  <= cmp_d;
      exc_q  <= exc_d;
    end
  end

  // Payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    dst_q  <= dst_d;
    pc_q   <= pc_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_rob_gen.sv
// Scoreboard bench for rob_gen: dispatch pushes expected {dst,data}, the retire
// monitor pops and compares in order.
module tb_rob_gen;
  localparam int DEPTH = 8, DISPATCH_W = 2, RETIRE_W = 2, WB_PORTS = 3, DATA_W = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  disp_valid;
  logic [9:0]  disp_dst;
  logic [63:0] disp_pc;
  logic        disp_ready;
  logic [5:0]  disp_tag;
  logic [2:0]  wb_valid;
  logic [8:0]  wb_tag;
  logic [95:0] wb_data;
  logic [2:0]  wb_exc;
  logic [1:0]  ret_valid;
  logic [9:0]  ret_dst;
  logic [63:0] ret_data;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        flush;
  logic [3:0]  count;

  int          errs = 0;
  int          checks = 0;
  int          mtail = 0;
  logic [31:0] mdata [8];
  logic [36:0] sbq [$];
  logic [36:0] mon_e;

  always #5 clk = ~clk;

  rob_gen #(
    .DEPTH(DEPTH), .DISPATCH_W(DISPATCH_W), .RETIRE_W(RETIRE_W),
    .WB_PORTS(WB_PORTS), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .resetn(resetn),
    .disp_valid(disp_valid), .disp_dst(disp_dst), .disp_pc(disp_pc),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_exc(wb_exc),
    .ret_valid(ret_valid), .ret_dst(ret_dst), .ret_data(ret_data),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .flush(flush), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    disp_valid = '0; disp_dst = '0; disp_pc = '0;
    wb_valid = '0; wb_tag = '0; wb_data = '0; wb_exc = '0;
    flush = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
    clr_in();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_in();
    resetn = 1'b0;
    disp_valid = 2'b11;
    wb_valid = 3'b111;
    #1;
    chk("rst_count", count, 0);
    chk("rst_ready", disp_ready, 1);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_exc_valid", exc_valid, 0);
    chk("rst_exc_pc", exc_pc, 0);
    chk("rst_disp_tag", disp_tag, 0);
    sbq.delete();
    mtail = 0;
    @(negedge clk);
    clr_in();
    resetn = 1'b1;
  endtask

  task automatic dsp(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    int          t;
    logic [4:0]  d;
    logic [31:0] dat;
    logic [2:0]  et [2];
    t = mtail;
    for (int l = 0; l < 2; l++) begin
      et[l] = 3'(t);
      if (v[l]) begin
        d   = 5'($urandom_range(0, 31));
        dat = $urandom;
        disp_dst[l*5 +: 5]  = d;
        disp_pc[l*32 +: 32] = (l == 0) ? pc0 : pc1;
        mdata[t % 8] = dat;
        sbq.push_back({d, dat});
        t++;
      end
    end
    disp_valid = v;
    #1;
    chk("disp_ready", disp_ready, 1);
    for (int l = 0; l < 2; l++)
      if (v[l]) chk("disp_tag", disp_tag[l*3 +: 3], et[l]);
    mtail = t;
  endtask

  task automatic wb(input int p, input int t, input logic e);
    wb_valid[p]          = 1'b1;
    wb_tag[p*3 +: 3]     = t[2:0];
    wb_data[p*32 +: 32]  = mdata[t];
    wb_exc[p]            = e;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 12 && sbq.size() != 0; i++) nxt();
    chk(tag, sbq.size(), 0);
  endtask

  always begin
    @(negedge clk);
    #2;
    for (int l = 0; l < 2; l++) begin
      if (ret_valid[l]) begin
        chk("ret_expected", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          mon_e = sbq.pop_front();
          chk("ret_dst", ret_dst[l*5 +: 5], mon_e[36:32]);
          chk("ret_data", ret_data[l*32 +: 32], mon_e[31:0]);
        end
      end else begin
        chk("ret_idle_zero", {ret_dst[l*5 +: 5], ret_data[l*32 +: 32]}, 0);
      end
    end
    if (exc_valid || flush) sbq.delete();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr_in();
    do_reset();

    // Allocation, lane skipping, back-pressure, two-lane retire
    nxt(); dsp(2'b11, 32'h1000, 32'h1004);
    nxt(); dsp(2'b11, 32'h1008, 32'h100C);
    nxt(); dsp(2'b11, 32'h1010, 32'h1014);
    nxt(); #1; chk("count6", count, 6); dsp(2'b10, 32'h0, 32'h1018);
    nxt(); #1; chk("count7", count, 7); chk("ready_full", disp_ready, 0); disp_valid = 2'b11;
    nxt(); #1; chk("count_hold", count, 7); wb(0, 1, 1'b0);
    nxt(); #1; chk("no_ret_tag1", ret_valid, 0); wb(0, 0, 1'b0);
    nxt(); #1; chk("ret_pair", ret_valid, 2'b11);
    nxt(); #1; chk("count5", count, 5); flush = 1'b1;
    nxt(); #1; chk("flush_count", count, 0); chk("flush_ready", disp_ready, 1);

    // Precise exception on entry 1
    do_reset();
    nxt(); dsp(2'b11, 32'h8000000C, 32'h80000010);
    nxt(); dsp(2'b11, 32'h80000014, 32'h80000018);
    nxt(); wb(0, 1, 1'b1); wb(1, 2, 1'b0); wb(2, 3, 1'b0);
    nxt(); #1; chk("exc_wait_ret", ret_valid, 0); chk("exc_wait", exc_valid, 0); wb(0, 0, 1'b0);
    nxt(); #1;
    chk("exc_ret", ret_valid, 2'b01);
    chk("exc_valid", exc_valid, 1);
    chk("exc_pc", exc_pc, 32'h80000010);
    disp_valid = 2'b11;
    nxt(); #1; chk("exc_count", count, 0); chk("exc_ret_after", ret_valid, 0); chk("exc_clear", exc_valid, 0);

    // Full buffer, pointer wrap, order preserved
    do_reset();
    for (int k = 0; k < 4; k++) begin
      nxt(); dsp(2'b11, 32'h2000 + 16*k, 32'h2004 + 16*k);
    end
    for (int it = 0; it < 5; it++) begin
      nxt(); #1; chk("wrap_full", count, 8); chk("wrap_ready0", disp_ready, 0);
      wb(0, (2*it) % 8, 1'b0); wb(1, (2*it + 1) % 8, 1'b0);
      nxt(); #1; chk("wrap_ret", ret_valid, 2'b11);
      nxt(); #1; chk("wrap_count6", count, 6); dsp(2'b11, 32'h2100 + 8*it, 32'h2104 + 8*it);
    end
    nxt(); #1; chk("wrap_end", count, 8);

    // Same-tag writeback priority, then flush concurrent with dispatch
    do_reset();
    nxt(); dsp(2'b11, 32'h3000, 32'h3004);
    nxt(); dsp(2'b11, 32'h3008, 32'h300C);
    sbq[3] = {sbq[3][36:32], 32'h0000BBBB};
    nxt();
    wb_valid = 3'b111;
    wb_tag   = {3'd3, 3'd0, 3'd3};
    wb_data  = {32'h0000BBBB, mdata[0], 32'h0000AAAA};
    nxt(); wb(0, 1, 1'b0); wb(1, 2, 1'b0);
    drain("same_tag_drain");
    nxt(); dsp(2'b11, 32'h3010, 32'h3014);
    nxt(); flush = 1'b1; disp_valid = 2'b11;
    nxt(); #1; chk("flush_disp_count", count, 0); dsp(2'b11, 32'h3018, 32'h301C);
    nxt(); #1; chk("post_flush_count", count, 2); wb(0, 6, 1'b0); wb(1, 7, 1'b0);
    drain("post_flush_drain");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
